// File: rtl/ring_router_demux_if.sv
// Flit channel between ring router stages: data/first/last/valid forward, ready back.
interface ring_router_demux_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] data;
  logic             first;
  logic             last;
  logic             valid;
  logic             ready;

  modport master (
    output data,
    output first,
    output last,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  first,
    input  last,
    input  valid,
    output ready
  );
endinterface

// File: rtl/ring_router_demux.sv
// Ring ingress demux: steers whole worms to the local sink or the next ring hop,
// with a one-entry output register per branch.
module ring_router_demux #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEST_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DEST_WIDTH-1:0] i_id,
  ring_router_demux_if.slave    i_in,
  ring_router_demux_if.master   o_local,
  ring_router_demux_if.master   o_ring,
  output logic                  o_err_drop
);

  typedef enum logic [1:0] {
    NOWORM     = 2'd0,
    WORM_LOCAL = 2'd1,
    WORM_RING  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_l_valid;
  logic [WIDTH-1:0] r_l_data;
  logic             r_l_first;
  logic             r_l_last;
  logic             r_r_valid;
  logic [WIDTH-1:0] r_r_data;
  logic             r_r_first;
  logic             r_r_last;

  logic             w_l_can_load;
  logic             w_r_can_load;
  logic             w_dest_local;
  logic             w_in_ready;
  logic             w_load_l;
  logic             w_load_r;
  logic             w_err_drop;

  // A branch register can take a flit when empty or draining this cycle.
  assign w_l_can_load = !r_l_valid || o_local.ready;
  assign w_r_can_load = !r_r_valid || o_ring.ready;
  assign w_dest_local = (i_in.data[DEST_WIDTH-1:0] == i_id);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= NOWORM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, input ready, branch load strobes and orphan-drop pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_load_l    = 1'b0;
    w_load_r    = 1'b0;
    w_err_drop  = 1'b0;
    case (r_state)
      NOWORM: begin
        if (i_in.valid) begin
          if (!i_in.first) begin
            // Orphan body flit: swallow it and flag the drop.
            w_in_ready = 1'b1;
            w_err_drop = 1'b1;
          end else if (w_dest_local) begin
            w_in_ready = w_l_can_load;
            w_load_l   = w_l_can_load;
            if (w_l_can_load && !i_in.last) begin
              w_state_nxt = WORM_LOCAL;
            end
          end else begin
            w_in_ready = w_r_can_load;
            w_load_r   = w_r_can_load;
            if (w_r_can_load && !i_in.last) begin
              w_state_nxt = WORM_RING;
            end
          end
        end
      end
      WORM_LOCAL: begin
        w_in_ready = w_l_can_load;
        w_load_l   = i_in.valid && w_l_can_load;
        if (w_load_l && i_in.last) begin
          w_state_nxt = NOWORM;
        end
      end
      WORM_RING: begin
        w_in_ready = w_r_can_load;
        w_load_r   = i_in.valid && w_r_can_load;
        if (w_load_r && i_in.last) begin
          w_state_nxt = NOWORM;
        end
      end
      default: begin
        w_state_nxt = NOWORM;
      end
    endcase
    if (rst) begin
      w_in_ready = 1'b0;
      w_load_l   = 1'b0;
      w_load_r   = 1'b0;
      w_err_drop = 1'b0;
    end
  end

  // Branch valid flags: set on load, cleared when drained without a refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_l_valid <= 1'b0;
      r_r_valid <= 1'b0;
    end else begin
      if (w_load_l) begin
        r_l_valid <= 1'b1;
      end else if (o_local.ready) begin
        r_l_valid <= 1'b0;
      end
      if (w_load_r) begin
        r_r_valid <= 1'b1;
      end else if (o_ring.ready) begin
        r_r_valid <= 1'b0;
      end
    end
  end

  // Branch payloads; only meaningful while the matching valid is set.
  always_ff @(posedge clk) begin
    if (w_load_l) begin
      r_l_data  <= i_in.data;
      r_l_first <= i_in.first;
      r_l_last  <= i_in.last;
    end
    if (w_load_r) begin
      r_r_data  <= i_in.data;
      r_r_first <= i_in.first;
      r_r_last  <= i_in.last;
    end
  end

  assign i_in.ready    = w_in_ready;
  assign o_err_drop    = w_err_drop;

  assign o_local.valid = r_l_valid;
  assign o_local.data  = r_l_data;
  assign o_local.first = r_l_first;
  assign o_local.last  = r_l_last;

  assign o_ring.valid  = r_r_valid;
  assign o_ring.data   = r_r_data;
  assign o_ring.first  = r_r_first;
  assign o_ring.last   = r_r_last;

endmodule

// File: tb/tb_ring_router_demux.sv
// Scoreboard bench for ring_router_demux: expected flits are queued per branch
// when the input handshakes and matched against each output handshake.
module tb_ring_router_demux;

  localparam int unsigned WIDTH      = 16;
  localparam int unsigned DEST_WIDTH = 10;
  localparam int unsigned BUDGET     = 50;

  logic                  clk;
  logic                  rst;
  logic [DEST_WIDTH-1:0] id;
  logic                  err_drop;

  ring_router_demux_if #(.WIDTH(WIDTH)) in_if ();
  ring_router_demux_if #(.WIDTH(WIDTH)) loc_if ();
  ring_router_demux_if #(.WIDTH(WIDTH)) ring_if ();

  ring_router_demux #(.WIDTH(WIDTH), .DEST_WIDTH(DEST_WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_id       (id),
    .i_in       (in_if),
    .o_local    (loc_if),
    .o_ring     (ring_if),
    .o_err_drop (err_drop)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected flits per branch: {data, first, last}.
  logic [WIDTH+1:0] q_loc[$];
  logic [WIDTH+1:0] q_ring[$];
  // Bench routing model: 0 = no worm, 1 = local worm, 2 = ring worm.
  int m_worm = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [WIDTH+1:0] got;
    logic [WIDTH+1:0] exp;
    logic             exp_err;
    logic             is_loc;
    if (!rst) begin
      if (loc_if.valid && loc_if.ready) begin
        got = {loc_if.data, loc_if.first, loc_if.last};
        checks++;
        if (q_loc.size() == 0) begin
          errors++;
          $display("FAIL local_unexpected got=%h expected none", got);
        end else begin
          exp = q_loc.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL local_flit got=%h expected=%h", got, exp);
          end
        end
      end
      if (ring_if.valid && ring_if.ready) begin
        got = {ring_if.data, ring_if.first, ring_if.last};
        checks++;
        if (q_ring.size() == 0) begin
          errors++;
          $display("FAIL ring_unexpected got=%h expected none", got);
        end else begin
          exp = q_ring.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL ring_flit got=%h expected=%h", got, exp);
          end
        end
      end
      exp_err = 1'b0;
      if (in_if.valid && in_if.ready) begin
        exp = {in_if.data, in_if.first, in_if.last};
        if (m_worm == 0) begin
          if (!in_if.first) begin
            exp_err = 1'b1;
          end else begin
            is_loc = (in_if.data[DEST_WIDTH-1:0] == id);
            if (is_loc) q_loc.push_back(exp);
            else        q_ring.push_back(exp);
            if (!in_if.last) m_worm = is_loc ? 1 : 2;
          end
        end else begin
          if (m_worm == 1) q_loc.push_back(exp);
          else             q_ring.push_back(exp);
          if (in_if.last) m_worm = 0;
        end
      end
      checks++;
      if (err_drop !== exp_err) begin
        errors++;
        $display("FAIL err_drop got=%b expected=%b", err_drop, exp_err);
      end
    end
  end

  // Present one flit and hold it until accepted.
  task automatic send(input logic [WIDTH-1:0] d, input logic f, input logic l);
    logic acc;
    in_if.data  = d;
    in_if.first = f;
    in_if.last  = l;
    in_if.valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < int'(BUDGET); i++) begin
      @(negedge clk);
      acc = in_if.ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout data=%h not accepted within %0d cycles", d, BUDGET);
    end
    in_if.valid = 1'b0;
  endtask

  // Wait until every expected flit has come out.
  task automatic drain();
    int n;
    n = 0;
    while ((q_loc.size() != 0 || q_ring.size() != 0) && n < int'(BUDGET)) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (q_loc.size() != 0 || q_ring.size() != 0) begin
      errors++;
      $display("FAIL drain local_left=%0d ring_left=%0d expected 0/0", q_loc.size(), q_ring.size());
    end
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    in_if.valid    = 1'b1;
    in_if.first    = 1'b1;
    in_if.last     = 1'b1;
    in_if.data     = 16'h0005;
    loc_if.ready   = 1'b1;
    ring_if.ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_if.ready !== 1'b0 || loc_if.valid !== 1'b0 || ring_if.valid !== 1'b0 || err_drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_state in_ready=%b lvalid=%b rvalid=%b err=%b expected 0000",
               in_if.ready, loc_if.valid, ring_if.valid, err_drop);
    end
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
    rst = 1'b0;
    m_worm = 0;
  endtask

  task automatic test_local_worm();
    send(16'h0005, 1'b1, 1'b0);
    checks++;
    if (loc_if.valid !== 1'b1 || loc_if.data !== 16'h0005 || loc_if.first !== 1'b1) begin
      errors++;
      $display("FAIL local_latency valid=%b data=%h first=%b expected 1/0005/1",
               loc_if.valid, loc_if.data, loc_if.first);
    end
    send(16'hAAAA, 1'b0, 1'b0);
    send(16'hBBBB, 1'b0, 1'b1);
    checks++;
    if (ring_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL local_worm_ring_quiet ring_valid=%b expected 0", ring_if.valid);
    end
    drain();
  endtask

  task automatic test_single_ring();
    int t0;
    t0 = cyc;
    send(16'h0007, 1'b1, 1'b1);
    send(16'h0005, 1'b1, 1'b1);
    checks++;
    if (cyc - t0 != 2) begin
      errors++;
      $display("FAIL single_then_local cycles=%0d expected 2", cyc - t0);
    end
    drain();
  endtask

  task automatic test_ring_stall();
    ring_if.ready = 1'b0;
    fork
      begin
        send(16'h0007, 1'b1, 1'b0);
        send(16'h1111, 1'b0, 1'b0);
        send(16'h2222, 1'b0, 1'b0);
        send(16'h3333, 1'b0, 1'b1);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_if.ready !== 1'b0 || ring_if.valid !== 1'b1 || ring_if.data !== 16'h0007) begin
          errors++;
          $display("FAIL ring_stall in_ready=%b rvalid=%b rdata=%h expected 0/1/0007",
                   in_if.ready, ring_if.valid, ring_if.data);
        end
        @(posedge clk);
        #1;
        ring_if.ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_orphan();
    in_if.data  = 16'h1234;
    in_if.first = 1'b0;
    in_if.last  = 1'b0;
    in_if.valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_if.ready !== 1'b1 || err_drop !== 1'b1) begin
      errors++;
      $display("FAIL orphan in_ready=%b err=%b expected 1/1", in_if.ready, err_drop);
    end
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
    @(negedge clk);
    checks++;
    if (loc_if.valid !== 1'b0 || ring_if.valid !== 1'b0 || err_drop !== 1'b0) begin
      errors++;
      $display("FAIL orphan_after lvalid=%b rvalid=%b err=%b expected 000",
               loc_if.valid, ring_if.valid, err_drop);
    end
    @(posedge clk);
    #1;
    send(16'h0005, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_reset_mid_worm();
    send(16'h0005, 1'b1, 1'b0);
    send(16'hC001, 1'b0, 1'b0);
    rst         = 1'b1;
    in_if.data  = 16'h1234;
    in_if.first = 1'b0;
    in_if.last  = 1'b0;
    in_if.valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_if.ready !== 1'b0 || err_drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_inputs in_ready=%b err=%b expected 0/0", in_if.ready, err_drop);
    end
    @(posedge clk);
    #1;
    checks++;
    if (loc_if.valid !== 1'b0 || ring_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_valids lvalid=%b rvalid=%b expected 0/0", loc_if.valid, ring_if.valid);
    end
    q_loc.delete();
    q_ring.delete();
    m_worm = 0;
    in_if.valid = 1'b0;
    rst = 1'b0;
    send(16'h0005, 1'b1, 1'b1);
    checks++;
    if (loc_if.valid !== 1'b1 || loc_if.data !== 16'h0005 || ring_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_reroute lvalid=%b ldata=%h rvalid=%b expected 1/0005/0",
               loc_if.valid, loc_if.data, ring_if.valid);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int t0;
    t0 = cyc;
    send(16'h0005, 1'b1, 1'b0);
    send(16'h0A01, 1'b0, 1'b0);
    send(16'h0A02, 1'b0, 1'b1);
    send(16'h03FF, 1'b1, 1'b0);
    send(16'h0B01, 1'b0, 1'b1);
    send(16'h0005, 1'b1, 1'b0);
    send(16'h0C01, 1'b0, 1'b1);
    checks++;
    if (cyc - t0 != 7) begin
      errors++;
      $display("FAIL back_to_back cycles=%0d expected 7", cyc - t0);
    end
    drain();
  endtask

  initial begin
    id           = 10'h005;
    rst          = 1'b1;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    in_if.first  = 1'b0;
    in_if.last   = 1'b0;
    loc_if.ready = 1'b1;
    ring_if.ready = 1'b1;
    test_reset();
    test_local_worm();
    test_single_ring();
    test_ring_stall();
    test_orphan();
    test_reset_mid_worm();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
